// File: rtl/ext_pipe_if.sv
// Handshake bundle for ext_pipe: request side (in_*), result side (out_*)
// and the illegal-request counter. The master drives requests and consumes
// results; the slave is the extension pipeline itself.
interface ext_pipe_if #(
    parameter int IN_W  = 16,
    parameter int OUT_W = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [IN_W-1:0]  in_data;
    logic [2:0]       in_mode;
    logic [1:0]       in_off;
    logic             out_valid;
    logic             out_ready;
    logic [OUT_W-1:0] out_data;
    logic             out_err;
    logic [7:0]       err_cnt;

    modport master (
        output in_valid, in_data, in_mode, in_off, out_ready,
        input  in_ready, out_valid, out_data, out_err, err_cnt
    );

    modport slave (
        input  in_valid, in_data, in_mode, in_off, out_ready,
        output in_ready, out_valid, out_data, out_err, err_cnt
    );
endinterface

// File: rtl/ext_pipe.sv
// Immediate-field extension unit. Each accepted request is extended
// (zero/sign/upper/shift/byte-lane) in one combinational step and written
// straight into a small output queue, so a request accepted into an empty
// queue is visible at the head one cycle later. Illegal requests travel
// through the queue as an all-zero word with the error bit set and are
// counted in a saturating 8-bit counter.
module ext_pipe #(
    parameter int IN_W  = 16,
    parameter int OUT_W = 32,
    parameter int DEPTH = 2
) (
    input  logic      clk,
    input  logic      rstn,
    ext_pipe_if.slave bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    localparam logic [2:0] MODE_ZERO   = 3'd0;
    localparam logic [2:0] MODE_SIGN   = 3'd1;
    localparam logic [2:0] MODE_UPPER  = 3'd2;
    localparam logic [2:0] MODE_SHL2   = 3'd3;
    localparam logic [2:0] MODE_BYTE_Z = 3'd4;
    localparam logic [2:0] MODE_BYTE_S = 3'd5;

    // Returns {err, result}; result is forced to zero whenever err is set.
    function automatic logic [OUT_W:0] extend(
        input logic [IN_W-1:0] data,
        input logic [2:0]      mode,
        input logic [1:0]      off
    );
        logic signed [IN_W-1:0]  data_s;
        logic signed [OUT_W-1:0] sext;
        logic [IN_W+23:0]        padded;
        logic [7:0]              lane;
        logic signed [7:0]       lane_s;
        logic                    lane_ok;
        logic [OUT_W-1:0]        result;
        logic                    err;

        data_s  = data;
        sext    = OUT_W'(data_s);
        // Padding keeps the lane shift in range for any offset; the
        // out-of-field lanes are rejected through lane_ok anyway.
        padded  = {24'd0, data};
        lane    = 8'(padded >> {off, 3'b000});
        lane_s  = lane;
        lane_ok = int'({off, 3'b111}) < IN_W;
        result  = '0;
        err     = 1'b0;

        case (mode)
            MODE_ZERO:   result = OUT_W'(data);
            MODE_SIGN:   result = $unsigned(sext);
            MODE_UPPER:  result = OUT_W'(data) << (OUT_W - IN_W);
            MODE_SHL2:   result = $unsigned(sext) << 2;
            MODE_BYTE_Z: begin
                if (lane_ok) result = OUT_W'(lane);
                else         err    = 1'b1;
            end
            MODE_BYTE_S: begin
                if (lane_ok) result = $unsigned(OUT_W'(lane_s));
                else         err    = 1'b1;
            end
            default:     err = 1'b1;
        endcase

        return {err, result};
    endfunction

    logic [OUT_W-1:0] data_p1 [DEPTH];
    logic             err_p1  [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic [7:0]       err_cnt;

    logic [OUT_W:0]   ext_p0;
    logic             out_valid;
    logic             push;
    logic             pop;

    // Stage p0: extension of the presented request
    assign ext_p0    = extend(bus.in_data, bus.in_mode, bus.in_off);

    // Ready/valid come from registered occupancy only, so nothing on the
    // result side ever depends combinationally on the request side.
    assign out_valid = (count != '0);
    assign push      = bus.in_valid && bus.in_ready;
    assign pop       = out_valid && bus.out_ready;

    assign bus.in_ready  = (count < CNT_W'(DEPTH));
    assign bus.out_valid = out_valid;
    assign bus.err_cnt   = err_cnt;
    // Queue storage is not reset; the empty-queue gate makes the result
    // port read zero until a real entry reaches the head.
    assign bus.out_data  = out_valid ? data_p1[rd_ptr] : '0;
    assign bus.out_err   = out_valid ? err_p1[rd_ptr]  : 1'b0;

    // Queue occupancy, pointers and the saturating illegal-request counter
    always_ff @(posedge clk) begin
        if (!rstn) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            err_cnt <= '0;
        end else begin
            // DEPTH is a power of two, so pointer overflow is the wrap.
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
            if (push && ext_p0[OUT_W] && (err_cnt != 8'hFF))
                err_cnt <= err_cnt + 8'd1;
        end
    end

    // Stage p1: write the extended result into the tail entry
    always_ff @(posedge clk) begin
        if (push) begin
            data_p1[wr_ptr] <= ext_p0[OUT_W-1:0];
            err_p1[wr_ptr]  <= ext_p0[OUT_W];
        end
    end
endmodule

// File: tb/tb_ext_pipe.sv
// Bench for ext_pipe (IN_W=16, OUT_W=32, DEPTH=2): directed vectors,
// back-pressure, streaming, randomized traffic and counter saturation,
// all compared against a queue-based reference model.
module tb_ext_pipe;
    localparam int IN_W  = 16;
    localparam int OUT_W = 32;
    localparam int DEPTH = 2;

    logic clk;
    logic rstn;

    ext_pipe_if #(.IN_W(IN_W), .OUT_W(OUT_W)) bus ();

    ext_pipe #(.IN_W(IN_W), .OUT_W(OUT_W), .DEPTH(DEPTH)) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    logic [32:0] q [$];      // expected queue contents, {err, data}
    int          m_err = 0;  // expected err_cnt
    bit          armed = 0;  // set once the first reset edge has been seen
    bit          fresh = 0;  // no entry written since the last reset
    bit          last_push;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Reference extension computed with plain integer arithmetic.
    function automatic logic [32:0] ref_ext(input logic [15:0] d, input logic [2:0] m, input logic [1:0] off);
        longint sv, b, r;
        sv = longint'(d);
        if (d >= 16'h8000) sv = sv - 65536;
        b = (longint'(d) >> (8 * off)) & 255;
        r = 0;
        case (m)
            3'd0: r = longint'(d);
            3'd1: r = sv;
            3'd2: r = longint'(d) * 65536;
            3'd3: r = sv * 4;
            3'd4, 3'd5: begin
                if (off > 2'd1) return {1'b1, 32'h0};
                r = (m == 3'd5 && b >= 128) ? b - 256 : b;
            end
            default: return {1'b1, 32'h0};
        endcase
        return {1'b0, r[31:0]};
    endfunction

    // One clock: check outputs at the falling edge, advance the model
    // across the rising edge, return 1 time unit after it.
    task automatic step();
        bit          push, pop;
        logic [32:0] head, r;
        @(negedge clk);
        if (armed) begin
            check("out_valid", bus.out_valid, q.size() != 0);
            check("in_ready", bus.in_ready, q.size() < DEPTH);
            check("err_cnt", bus.err_cnt, m_err);
            if (q.size() != 0) begin
                head = q[0];
                check("out_data", bus.out_data, head[31:0]);
                check("out_err", bus.out_err, head[32]);
            end else if (fresh) begin
                check("rst_data", bus.out_data, 0);
                check("rst_err", bus.out_err, 0);
            end
        end
        push = rstn && bus.in_valid && (q.size() < DEPTH);
        pop  = rstn && bus.out_ready && (q.size() != 0);
        r    = ref_ext(bus.in_data, bus.in_mode, bus.in_off);
        @(posedge clk);
        last_push = 0;
        if (!rstn) begin
            q.delete();
            m_err = 0;
            fresh = 1;
            armed = 1;
        end else begin
            if (pop) void'(q.pop_front());
            if (push) begin
                q.push_back(r);
                fresh = 0;
                last_push = 1;
                if (r[32] && m_err < 255) m_err++;
            end
        end
        #1;
    endtask

    task automatic drive(input bit v, input logic [15:0] d, input logic [2:0] m, input logic [1:0] off, input bit rdy);
        bus.in_valid  = v;
        bus.in_data   = d;
        bus.in_mode   = m;
        bus.in_off    = off;
        bus.out_ready = rdy;
    endtask

    // Push one request into an empty queue and compare the head with a constant.
    task automatic directed(input string tag, input logic [15:0] d, input logic [2:0] m, input logic [1:0] off,
                            input logic [31:0] exp_d, input logic exp_e);
        drive(1, d, m, off, 0);
        step();
        bus.in_valid = 0;
        check({tag, "_vld"}, bus.out_valid, 1);
        check({tag, "_dat"}, bus.out_data, exp_d);
        check({tag, "_err"}, bus.out_err, exp_e);
        bus.out_ready = 1;
        step();
    endtask

    initial begin
        bit done;

        // Reset with a request presented: it must not be accepted.
        rstn = 0;
        drive(1, 16'h1234, 3'd0, 2'd0, 1);
        repeat (3) step();
        rstn = 1;
        bus.in_valid = 0;
        step();
        check("rst_valid", bus.out_valid, 0);
        check("rst_ready", bus.in_ready, 1);
        check("rst_cnt", bus.err_cnt, 0);

        // Directed extension vectors
        directed("sign",   16'h8001, 3'd1, 2'd0, 32'hFFFF8001, 0);
        directed("zero",   16'h8001, 3'd0, 2'd0, 32'h00008001, 0);
        directed("upper",  16'h8001, 3'd2, 2'd0, 32'h80010000, 0);
        directed("shl2",   16'h8001, 3'd3, 2'd0, 32'hFFFE0004, 0);
        directed("bs0",    16'h80F0, 3'd5, 2'd0, 32'hFFFFFFF0, 0);
        directed("bs1",    16'h80F0, 3'd5, 2'd1, 32'hFFFFFF80, 0);
        directed("bz1",    16'h80F0, 3'd4, 2'd1, 32'h00000080, 0);
        directed("bs2",    16'h80F0, 3'd5, 2'd2, 32'h00000000, 1);
        check("err_one", bus.err_cnt, 1);
        directed("mode6",  16'h0055, 3'd6, 2'd0, 32'h00000000, 1);
        check("err_two", bus.err_cnt, 2);

        // Back-pressure: three back-to-back pushes into a 2-entry queue.
        drive(1, 16'h0011, 3'd0, 2'd0, 0);
        step();
        bus.in_data = 16'h0022;
        step();
        check("full_ready", bus.in_ready, 0);
        bus.in_data = 16'h0033;
        step();
        check("full_hold", bus.out_data, 32'h00000011);
        bus.out_ready = 1;
        done = 0;
        for (int i = 0; i < 10 && !done; i++) begin
            step();
            if (last_push) done = 1;
        end
        check("third_accepted", done, 1);
        bus.in_valid = 0;
        repeat (4) step();

        // Streaming: one entry held, push and pop together for 10 cycles.
        drive(1, 16'h0100, 3'd1, 2'd0, 0);
        step();
        bus.out_ready = 1;
        for (int i = 0; i < 10; i++) begin
            bus.in_data = 16'(16'h0101 + i);
            bus.in_mode = 3'(i % 6);
            step();
            check("stream_occ", q.size(), 1);
        end
        bus.in_valid = 0;
        repeat (2) step();

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            drive($urandom_range(0, 3) != 0, 16'($urandom), 3'($urandom_range(0, 7)),
                  2'($urandom_range(0, 3)), $urandom_range(0, 2) != 0);
            step();
        end
        bus.in_valid  = 0;
        bus.out_ready = 1;
        repeat (3) step();

        // Counter saturation with 300 mode-7 requests
        drive(1, 16'hABCD, 3'd7, 2'd0, 1);
        repeat (300) step();
        bus.in_valid = 0;
        step();
        check("err_sat", bus.err_cnt, 255);

        // Reset with two entries queued
        drive(1, 16'h0F0F, 3'd0, 2'd0, 0);
        repeat (2) step();
        check("pre_rst_full", bus.in_ready, 0);
        rstn = 0;
        step();
        rstn = 1;
        bus.in_valid = 0;
        step();
        check("rst2_valid", bus.out_valid, 0);
        check("rst2_cnt", bus.err_cnt, 0);
        check("rst2_ready", bus.in_ready, 1);
        check("rst2_data", bus.out_data, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/ext_pipe.md
EXT_PIPE -- requirements
Module: ext_pipe

Interface
REQ-001 Parameter IN_W, default 16, immediate field width; legal range 8..OUT_W.
REQ-002 Parameter OUT_W, default 32, extended result width.
REQ-003 Parameter DEPTH, default 2, output queue entries; legal values 2 or 4.
REQ-004 clk  input  1  sole clock; all state updates on rising edge.
REQ-005 rstn  input  1  reset, synchronous, active-low.
REQ-006 in_valid  input  1  producer presents a request.
REQ-007 in_ready  output  1  block can accept a request this cycle.
REQ-008 in_data  input  IN_W  immediate or raw field.
REQ-009 in_mode  input  3  extension mode, encoding per REQ-014.
REQ-010 in_off  input  2  byte lane select for byte modes.
REQ-011 out_valid  output  1  queue head holds a result.
REQ-012 out_ready  input  1  consumer takes the head this cycle.
REQ-013 out_data  output  OUT_W  extended result; out_err  output  1  head entry flagged illegal; err_cnt  output  8  illegal-request count.

Function
REQ-014 Modes: 0 ZERO = {0, in_data}; 1 SIGN = {in_data[IN_W-1] replicated, in_data}; 2 UPPER = in_data << (OUT_W-IN_W), low bits zero; 3 SHL2 = SIGN result << 2, truncated to OUT_W; 4 BYTE_Z = zero-extended byte in_data[8*in_off +: 8]; 5 BYTE_S = same byte sign-extended from its bit 7.
REQ-015 Modes 4/5 with 8*in_off+7 >= IN_W are illegal; modes 6 and 7 are illegal.
REQ-016 Illegal request: enqueued with data all-zero and err bit 1; legal request: err bit 0.
REQ-017 Transfer in: in_valid && in_ready at a rising edge; computed result written to tail entry.
REQ-018 Transfer out: out_valid && out_ready at a rising edge; head entry removed.
REQ-019 Latency: request accepted at edge T appears on out_data/out_err with out_valid=1 after edge T when queue was empty (one cycle); no combinational path from in_* to out_*.
REQ-020 in_ready = (count < DEPTH); depends only on registered state, not on out_ready.
REQ-021 out_valid = (count != 0); out_data/out_err driven from head entry registers.
REQ-022 Simultaneous in and out transfer: count unchanged, pointers both advance, FIFO order preserved.
REQ-023 Full (count = DEPTH): in_ready=0; in_valid ignored; a pop in the same cycle does not enable a push that cycle.
REQ-024 Empty: out_ready ignored; count never underflows.
REQ-025 Read/write pointers wrap modulo DEPTH; count width holds 0..DEPTH.
REQ-026 Head entry stable while out_valid=1 and out_ready=0.
REQ-027 err_cnt increments by 1 on each accepted illegal request; saturates at 255.
REQ-028 Inputs with in_valid=0 have no effect on state.

Reset
REQ-029 rstn=0 at a rising edge: count=0, pointers=0, err_cnt=0; out_valid=0, in_ready=1 after that edge.
REQ-030 out_data and out_err read 0 after reset until first entry written.
REQ-031 Reset mid-operation discards all queued entries; requests presented during reset are not accepted.

Verification
REQ-032 IN_W=16: in_data=16'h8001 mode 1 -> 32'hFFFF8001; mode 0 -> 32'h00008001; mode 2 -> 32'h80010000; mode 3 -> 32'hFFFE0004; each one cycle after acceptance.
REQ-033 in_data=16'h80F0, mode 5 in_off=0 -> 32'hFFFFFFF0; in_off=1 -> 32'hFFFFFF80; mode 4 in_off=1 -> 32'h00000080; mode 5 in_off=2 -> data 0, out_err=1, err_cnt=1.
REQ-034 DEPTH=2, out_ready=0, push 3 requests back-to-back -> in_ready=0 after second; release out_ready -> first two results out in order, third accepted only after a slot frees.
REQ-035 Queue holding 1 entry, simultaneous push and pop for 10 cycles -> count stays 1, results emerge in order with one-cycle spacing.
REQ-036 300 mode-7 requests -> err_cnt saturates at 255; rstn=0 one edge with 2 entries queued -> out_valid=0, err_cnt=0, in_ready=1.
